// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_pkg                                                    |
// | Brief    : Shared PWM types and helpers (sequencer state, index size) |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } pwm_state_t;

   // Channel-select width, never narrower than one bit so a single channel still has a port.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_prescaler                                              |
// | Brief    : PRESCALE-cycle clock-enable generator for the PWM counter  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pwm_prescaler #(
   parameter int PRESCALE = 606
) (
   input  logic clk_in,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);

   logic [c_pre_w-1:0] r_pre_cnt;

   assign tick = run && (r_pre_cnt == c_pre_max);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_pre_cnt <= '0;
      end else if (!run || tick) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pwm_seq_ctrl                                               |
// | Brief    : Multi-channel PWM sequencer with ramped duty updates       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pwm_seq_ctrl
   import pwm_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 10,
   parameter int PRESCALE  = 606,
   parameter int PERIOD    = 1000,
   parameter int RAMP_STEP = 8
) (
   input  logic                        clk_in,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]            cfg_duty,
   output logic [NUM_CH-1:0]           pwm_out,
   output logic                        period_tick,
   output logic                        busy
);

   localparam int               c_ch_w   = ch_idx_w(NUM_CH);
   localparam logic [CNT_W-1:0] c_period = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] c_last   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] c_step   = CNT_W'(RAMP_STEP);

   pwm_state_t         r_state;
   pwm_state_t         w_state_nxt;
   logic               w_run;
   logic               w_tick;
   logic               w_wrap;
   logic               w_cfg_fire;
   logic [CNT_W-1:0]   w_duty_clamped;
   logic [CNT_W-1:0]   r_per_cnt;
   logic [NUM_CH-1:0]  w_pwm_nxt;
   logic [NUM_CH-1:0]  r_pwm;

   assign w_run          = (r_state != ST_IDLE);
   assign w_wrap         = w_tick && (r_per_cnt == c_last);
   assign w_cfg_fire     = cfg_valid && cfg_ready;
   assign w_duty_clamped = (cfg_duty > c_period) ? c_period : cfg_duty;

   assign cfg_ready   = (r_state != ST_DRAIN);
   assign busy        = w_run;
   assign period_tick = w_wrap;
   assign pwm_out     = r_pwm;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_in (clk_in),
      .rst    (rst),
      .run    (w_run),
      .tick   (w_tick)
   );

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // DRAIN lets the current period finish so no channel sees a truncated pulse.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
         ST_RUN:   if (!enable) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (enable) begin
               w_state_nxt = ST_RUN;
            end else if (w_wrap) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_per_cnt <= '0;
      end else if (!w_run) begin
         r_per_cnt <= '0;
      end else if (w_tick) begin
         r_per_cnt <= (r_per_cnt == c_last) ? '0 : r_per_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= w_pwm_nxt;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_target;
      logic [CNT_W-1:0] r_active;
      logic             w_wr_hit;
      logic             w_up;
      logic [CNT_W-1:0] w_diff;

      // Out-of-range channel indices match no instance, so those writes are dropped.
      assign w_wr_hit = w_cfg_fire && (cfg_ch == c_ch_w'(i));
      assign w_up     = (r_target >= r_active);
      assign w_diff   = w_up ? (r_target - r_active) : (r_active - r_target);

      assign w_pwm_nxt[i] = w_run && (r_per_cnt < r_active);

      always_ff @(posedge clk_in or posedge rst) begin
         if (rst) begin
            r_target <= '0;
         end else if (w_wr_hit) begin
            r_target <= w_duty_clamped;
         end
      end

      // Ramp reads r_target before a same-cycle write lands, so the new target waits a period.
      always_ff @(posedge clk_in or posedge rst) begin
         if (rst) begin
            r_active <= '0;
         end else if (r_state == ST_IDLE) begin
            r_active <= r_target;
         end else if ((r_state == ST_RUN) && w_wrap) begin
            if (w_diff <= c_step) begin
               r_active <= r_target;
            end else if (w_up) begin
               r_active <= r_active + c_step;
            end else begin
               r_active <= r_active - c_step;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pwm_seq_ctrl                                            |
// | Brief    : Scoreboard bench: per-period high counts for each channel  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pwm_seq_ctrl;

   localparam int c_num_ch   = 3;
   localparam int c_cnt_w    = 10;
   localparam int c_prescale = 3;
   localparam int c_period   = 24;
   localparam int c_ramp     = 8;

   logic               clk_in = 1'b0;
   logic               rst;
   logic               enable;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [1:0]         cfg_ch;
   logic [c_cnt_w-1:0] cfg_duty;
   logic [c_num_ch-1:0] pwm_out;
   logic               period_tick;
   logic               busy;

   typedef logic [c_num_ch-1:0][15:0] exp_t;
   exp_t exp_q[$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   acc[c_num_ch];
   int   len = 0;
   logic tick_d = 1'b0;

   always #5 clk_in = ~clk_in;

   pwm_seq_ctrl #(
      .NUM_CH    (c_num_ch),
      .CNT_W     (c_cnt_w),
      .PRESCALE  (c_prescale),
      .PERIOD    (c_period),
      .RAMP_STEP (c_ramp)
   ) u_dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .enable      (enable),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_duty    (cfg_duty),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .busy        (busy)
   );

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Expected duty in counts; each count lasts c_prescale clocks.
   task automatic push_exp(input int d0, input int d1, input int d2);
      exp_t e;
      e[0] = 16'(d0 * c_prescale);
      e[1] = 16'(d1 * c_prescale);
      e[2] = 16'(d2 * c_prescale);
      exp_q.push_back(e);
   endtask

   task automatic write_cfg(input int ch, input int duty);
      cfg_ch    = 2'(ch);
      cfg_duty  = c_cnt_w'(duty);
      cfg_valid = 1'b1;
      @(posedge clk_in);
      #1 cfg_valid = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!period_tick && n < 400);
      if (!period_tick) check_val("tick_timeout", 0, 1);
   endtask

   // The sample after period_tick carries the last count of the period (one-clock output latency).
   always @(negedge clk_in) begin
      if (rst) begin
         for (int c = 0; c < c_num_ch; c++) acc[c] = 0;
         len    = 0;
         tick_d = 1'b0;
      end else begin
         for (int c = 0; c < c_num_ch; c++) acc[c] += int'(pwm_out[c]);
         if (tick_d) begin
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               for (int c = 0; c < c_num_ch; c++)
                  check_val($sformatf("high_cnt_ch%0d", c), acc[c], int'(e[c]));
            end
            for (int c = 0; c < c_num_ch; c++) acc[c] = 0;
         end
         if (busy) len++;
         else      len = 0;
         if (period_tick) begin
            check_val("period_len", len, c_period * c_prescale);
            len = 0;
         end
         tick_d = period_tick;
      end
   end

   initial begin
      int n;
      rst       = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_duty  = '0;
      repeat (3) @(posedge clk_in);
      #1;
      check_val("rst_pwm", int'(pwm_out), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_ready", int'(cfg_ready), 1);
      check_val("rst_tick", int'(period_tick), 0);
      rst = 1'b0;
      @(posedge clk_in);
      #1;

      // Idle writes apply directly; 1023 clamps to PERIOD; channel 3 does not exist.
      write_cfg(0, 3);
      write_cfg(1, 0);
      write_cfg(2, 1023);
      write_cfg(3, 7);
      @(posedge clk_in);
      #1;
      push_exp(3, 0, 24);
      push_exp(3, 8, 16);
      push_exp(3, 16, 8);
      push_exp(3, 20, 0);
      push_exp(11, 20, 0);
      push_exp(11, 20, 0);
      enable = 1'b1;
      repeat (10) @(posedge clk_in);
      #1;
      check_val("run_busy", int'(busy), 1);
      write_cfg(1, 20);
      write_cfg(2, 0);
      wait_tick();
      wait_tick();
      wait_tick();
      // Driven at the negedge of the wrap cycle: transfer coincides with the ramp edge.
      write_cfg(0, 11);
      wait_tick();
      repeat (10) @(posedge clk_in);
      #1;
      write_cfg(3, 5);
      wait_tick();
      repeat (10) @(posedge clk_in);
      #1;
      enable = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      check_val("drain_ready", int'(cfg_ready), 0);
      check_val("drain_busy", int'(busy), 1);
      cfg_ch    = 2'd2;
      cfg_duty  = c_cnt_w'(5);
      cfg_valid = 1'b1;
      repeat (2) @(posedge clk_in);
      #1 cfg_valid = 1'b0;
      wait_tick();
      @(negedge clk_in);
      check_val("idle_busy", int'(busy), 0);
      check_val("idle_ready", int'(cfg_ready), 1);
      @(negedge clk_in);
      check_val("idle_pwm", int'(pwm_out), 0);

      // 25 clamps to 24: ramp toward 7 gives 16 (an unclamped 25 would give 17).
      write_cfg(1, 25);
      @(posedge clk_in);
      #1;
      push_exp(11, 24, 0);
      push_exp(11, 16, 0);
      enable = 1'b1;
      repeat (10) @(posedge clk_in);
      #1;
      write_cfg(1, 7);
      wait_tick();
      wait_tick();
      repeat (10) @(posedge clk_in);
      #1;
      check_val("pre_rst_pwm0", int'(pwm_out[0]), 1);
      #3 rst = 1'b1;
      #1;
      check_val("mid_rst_pwm", int'(pwm_out), 0);
      check_val("mid_rst_ready", int'(cfg_ready), 1);
      check_val("mid_rst_busy", int'(busy), 0);
      check_val("mid_rst_tick", int'(period_tick), 0);
      check_val("sb_before_rst", exp_q.size(), 0);
      enable = 1'b0;
      @(posedge clk_in);
      #1 rst = 1'b0;

      // Cleared targets show up as zero duty on every channel.
      push_exp(0, 0, 0);
      enable = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk_in);
         n++;
      end
      check_val("sb_final", exp_q.size(), 0);
      enable = 1'b0;
      repeat (5) @(negedge clk_in);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
